// File: rtl/instr_fetch_if.sv
// Fetch-to-decode handshake bundle.
// Fetch drives the head entry, decode answers with ready.
interface instr_fetch_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    output out_pc4,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_pc4,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, combinational imem port,
// prefetch FIFO toward decode, flushed on redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          CLK,
  input  logic          rst_n,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  instr_fetch_if.master dec
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

  entry_t        fifo [DEPTH];
  entry_t        head;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [31:0]   tgt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push;

  assign pc_nxt = pc + 32'd4;
  assign tgt    = redirect_pc & ~32'd3;
  assign pop    = (count != '0) && dec.out_ready;
  assign push   = !redirect && ((count < FULL) || pop);

  assign imem_addr = pc;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= tgt;
    end else if (push) begin
      pc <= pc_nxt;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (redirect) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: count <= count + (AW+1)'(1);
        pop && !push: count <= count - (AW+1)'(1);
        default:      count <= count;
      endcase
    end
  end

  // pc4 is stored so a cleared entry reads back as all zeros
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else if (push) begin
      fifo[wr_ptr] <= '{pc: pc, pc4: pc_nxt, instr: imem_rdata};
    end
  end

  assign head          = fifo[rd_ptr];
  assign dec.out_valid = (count != '0);
  assign dec.out_instr = head.instr;
  assign dec.out_pc    = head.pc;
  assign dec.out_pc4   = head.pc4;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model on the imem port,
// expected PC stream kept in a scoreboard queue.
module tb_instr_fetch;

  logic        CLK;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem [64];
  logic [31:0] exp_q [$];
  int          checks;
  int          errors;

  instr_fetch_if dec_if ();

  instr_fetch dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec         (dec_if)
  );

  assign imem_rdata = mem[imem_addr[7:2]];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    dec_if.out_ready = rdy;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    dec_if.out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (dec_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b exp 0", dec_if.out_valid);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h exp 0", imem_addr);
    end
    checks++;
    if ({dec_if.out_instr, dec_if.out_pc, dec_if.out_pc4} !== 96'h0) begin
      errors++;
      $display("FAIL reset_head: got %h %h %h exp zeros",
               dec_if.out_instr, dec_if.out_pc, dec_if.out_pc4);
    end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    do_reset(1'b1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (dec_if.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid: cycle %0d got %b exp 1", i, dec_if.out_valid);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dec_if.out_pc !== e || dec_if.out_instr !== mem[e[7:2]]
            || dec_if.out_pc4 !== e + 32'd4) begin
          errors++;
          $display("FAIL stream_head: got %h/%h/%h exp %h/%h/%h",
                   dec_if.out_pc, dec_if.out_instr, dec_if.out_pc4,
                   e, mem[e[7:2]], e + 32'd4);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_left: got %0d pending exp 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    do_reset(1'b0);
    repeat (5) @(negedge CLK);
    checks++;
    if (dut.count !== 2'd2 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL bp_stall: got count %0d addr %h exp 2 00000008",
               dut.count, imem_addr);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    dec_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dec_if.out_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL bp_valid: cycle %0d got %b exp 1", i, dec_if.out_valid);
      end else begin
        e = exp_q.pop_front();
        if (dec_if.out_pc !== e || dec_if.out_instr !== mem[e[7:2]]) begin
          errors++;
          $display("FAIL bp_head: got %h/%h exp %h/%h",
                   dec_if.out_pc, dec_if.out_instr, e, mem[e[7:2]]);
        end
      end
      @(negedge CLK);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_left: got %0d pending exp 0", exp_q.size());
    end
  endtask

  task automatic test_full_pushpop;
    do_reset(1'b0);
    repeat (3) @(negedge CLK);
    dec_if.out_ready = 1'b1;
    @(negedge CLK);
    dec_if.out_ready = 1'b0;
    checks++;
    if (dut.count !== 2'd2 || imem_addr !== 32'hC || dec_if.out_pc !== 32'h4) begin
      errors++;
      $display("FAIL full_pp: got count %0d addr %h pc %h exp 2 0000000c 00000004",
               dut.count, imem_addr, dec_if.out_pc);
    end
  endtask

  task automatic test_redirect;
    logic [31:0] e;
    do_reset(1'b1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    exp_q.push_back(32'h18);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (c == 2) begin
        redirect = 1'b0;
        checks++;
        if (dec_if.out_valid !== 1'b0 || imem_addr !== 32'h10) begin
          errors++;
          $display("FAIL redir_bubble: got valid %b addr %h exp 0 00000010",
                   dec_if.out_valid, imem_addr);
        end
      end else if (dec_if.out_valid && dec_if.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL redir_extra: got pc %h exp none", dec_if.out_pc);
        end else begin
          e = exp_q.pop_front();
          if (dec_if.out_pc !== e || dec_if.out_instr !== mem[e[7:2]]) begin
            errors++;
            $display("FAIL redir_head: got %h/%h exp %h/%h",
                     dec_if.out_pc, dec_if.out_instr, e, mem[e[7:2]]);
          end
        end
      end
      if (c == 1) begin
        redirect = 1'b1;
        redirect_pc = 32'h13;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL redir_left: got %0d pending exp 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_full;
    do_reset(1'b0);
    repeat (3) @(negedge CLK);
    redirect = 1'b1;
    redirect_pc = 32'h0;
    @(negedge CLK);
    redirect = 1'b0;
    checks++;
    if (dec_if.out_valid !== 1'b0 || imem_addr !== 32'h0 || dut.count !== 2'd0) begin
      errors++;
      $display("FAIL rfull_flush: got valid %b addr %h count %0d exp 0 0 0",
               dec_if.out_valid, imem_addr, dut.count);
    end
    dec_if.out_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h0
        || dec_if.out_instr !== 32'h20110001) begin
      errors++;
      $display("FAIL rfull_head: got %b %h %h exp 1 00000000 20110001",
               dec_if.out_valid, dec_if.out_pc, dec_if.out_instr);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] e;
    do_reset(1'b0);
    repeat (3) @(negedge CLK);
    checks++;
    if (dut.count !== 2'd2) begin
      errors++;
      $display("FAIL arst_pre: got count %0d exp 2", dut.count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dec_if.out_valid !== 1'b0 || imem_addr !== 32'h0 || dec_if.out_pc !== 32'h0) begin
      errors++;
      $display("FAIL arst_now: got valid %b addr %h pc %h exp 0 0 0",
               dec_if.out_valid, imem_addr, dec_if.out_pc);
    end
    @(negedge CLK);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    dec_if.out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (dec_if.out_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL arst_valid: cycle %0d got %b exp 1", i, dec_if.out_valid);
      end else begin
        e = exp_q.pop_front();
        if (dec_if.out_pc !== e || dec_if.out_instr !== mem[e[7:2]]) begin
          errors++;
          $display("FAIL arst_head: got %h/%h exp %h/%h",
                   dec_if.out_pc, dec_if.out_instr, e, mem[e[7:2]]);
        end
      end
    end
  endtask

  task automatic test_wrap;
    do_reset(1'b1);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge CLK);
    redirect = 1'b0;
    @(negedge CLK);
    checks++;
    if (dec_if.out_pc !== 32'hFFFF_FFFC || dec_if.out_pc4 !== 32'h0
        || dec_if.out_instr !== mem[63]) begin
      errors++;
      $display("FAIL wrap_top: got %h/%h/%h exp fffffffc/00000000/%h",
               dec_if.out_pc, dec_if.out_pc4, dec_if.out_instr, mem[63]);
    end
    @(negedge CLK);
    checks++;
    if (dec_if.out_pc !== 32'h0 || dec_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero: got %h valid %b exp 00000000 1",
               dec_if.out_pc, dec_if.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    mem[0] = 32'h2011_0001;
    mem[1] = 32'h2010_0000;
    mem[2] = 32'h2008_0065;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pushpop();
    test_redirect();
    test_redirect_full();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
